// File: rtl/bsg_mesh_inject_pkg.sv
// Shared definitions for the mesh injection arbiter: the packet layout,
// the drop counter width, queue operation codes and a saturating increment.
package bsg_mesh_inject_pkg;

   // Width of the dropped-packet counter
   localparam int drop_count_width_lp = 8;

   // Field widths of the default configuration
   localparam int pkt_x_cord_width_lp  = 1;
   localparam int pkt_y_cord_width_lp  = 1;
   localparam int pkt_payload_width_lp = 4;

   // Packet layout of the default configuration. Packed structs place the
   // first member at the MSB, so dst_x is declared last and lands in the low
   // bits. The low bits carry the routing destination that the router expects.
   typedef struct packed {
      logic [pkt_payload_width_lp-1:0] payload;
      logic [pkt_y_cord_width_lp-1:0]  src_y;
      logic [pkt_x_cord_width_lp-1:0]  src_x;
      logic [pkt_y_cord_width_lp-1:0]  dst_y;
      logic [pkt_x_cord_width_lp-1:0]  dst_x;
   } bsg_mesh_inject_packet_t;

   // Queue operation in a cycle, encoded as {enqueue, dequeue}
   typedef enum logic [1:0] {
      e_q_idle = 2'b00,
      e_q_deq  = 2'b01,
      e_q_enq  = 2'b10,
      e_q_both = 2'b11
   } bsg_mesh_inject_q_op_e;

   // Increment that holds at the all-ones value
   function automatic logic [drop_count_width_lp-1:0] sat_inc
      (input logic [drop_count_width_lp-1:0] cnt);
      logic [drop_count_width_lp-1:0] res;
      if (cnt == {drop_count_width_lp{1'b1}}) begin
         res = cnt;
      end else begin
         res = cnt + {{(drop_count_width_lp-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/bsg_mesh_inject_rr_grant.sv
// Rotating-priority one-hot arbiter. The search for a valid requester starts
// at rr_ptr and wraps explicitly from num_req_p-1 back to 0. This keeps the
// wrap correct when num_req_p is not a power of two.
module bsg_mesh_inject_rr_grant
   import bsg_mesh_inject_pkg::*;
#(
   parameter int num_req_p   = 4,
   parameter int ptr_width_p = 2
)
(
   input  logic [num_req_p-1:0]   reqs,
   input  logic [ptr_width_p-1:0] rr_ptr,
   output logic [num_req_p-1:0]   grant,
   output logic [ptr_width_p-1:0] winner,
   output logic                   any_grant
);

   logic [ptr_width_p:0] idx_s;

   // Walk the requesters in priority order from rr_ptr and pick the first valid one
   always_comb begin
      grant     = {num_req_p{1'b0}};
      winner    = {ptr_width_p{1'b0}};
      any_grant = 1'b0;
      idx_s     = {(ptr_width_p+1){1'b0}};
      for (int i = 0; i < num_req_p; i++) begin
         idx_s = {1'b0, rr_ptr} + (ptr_width_p+1)'(i);
         if (idx_s >= (ptr_width_p+1)'(num_req_p)) begin
            idx_s = idx_s - (ptr_width_p+1)'(num_req_p);
         end else begin
            idx_s = idx_s;
         end
         if (!any_grant && reqs[idx_s[ptr_width_p-1:0]]) begin
            any_grant                         = 1'b1;
            winner                            = idx_s[ptr_width_p-1:0];
            grant[idx_s[ptr_width_p-1:0]]     = 1'b1;
         end else begin
            any_grant = any_grant;
         end
      end
   end

endmodule

// File: rtl/bsg_mesh_inject_arbiter.sv
// Shares one mesh router P input port among num_req_p local requesters.
// A round-robin winner is picked each cycle and its header is formed. The
// flit is then buffered in a 2-entry queue with a registered head. Packets
// whose destination lies outside the mesh are accepted, dropped and counted.
module bsg_mesh_inject_arbiter
   import bsg_mesh_inject_pkg::*;
#(
   parameter int num_req_p       = 4,
   parameter int payload_width_p = 4,
   parameter int x_cord_width_p  = 1,
   parameter int y_cord_width_p  = 1,
   parameter int mesh_x_p        = 2,
   parameter int mesh_y_p        = 2,
   localparam int width_lp = 2*x_cord_width_p + 2*y_cord_width_p + payload_width_p
)
(
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic [x_cord_width_p-1:0]             my_x_i,
   input  logic [y_cord_width_p-1:0]             my_y_i,
   input  logic [num_req_p-1:0]                  v_i,
   input  logic [num_req_p*x_cord_width_p-1:0]   dst_x_i,
   input  logic [num_req_p*y_cord_width_p-1:0]   dst_y_i,
   input  logic [num_req_p*payload_width_p-1:0]  payload_i,
   output logic [num_req_p-1:0]                  ready_o,
   output logic                                  v_o,
   output logic [width_lp-1:0]                   data_o,
   input  logic                                  yumi_i,
   output logic                                  err_o,
   output logic [drop_count_width_lp-1:0]        drop_count_o
);

   localparam int ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam logic [x_cord_width_p:0] mesh_x_lp = (x_cord_width_p+1)'(mesh_x_p);
   localparam logic [y_cord_width_p:0] mesh_y_lp = (y_cord_width_p+1)'(mesh_y_p);

   // Same field order as the package packet type, sized by this instance
   typedef struct packed {
      logic [payload_width_p-1:0] payload;
      logic [y_cord_width_p-1:0]  src_y;
      logic [x_cord_width_p-1:0]  src_x;
      logic [y_cord_width_p-1:0]  dst_y;
      logic [x_cord_width_p-1:0]  dst_x;
   } packet_t;

   logic [ptr_width_lp-1:0]         rr_ptr_r;
   logic [ptr_width_lp-1:0]         rr_ptr_n_s;
   logic [num_req_p-1:0]            grant_s;
   logic [ptr_width_lp-1:0]         winner_s;
   logic                            any_grant_s;

   logic [x_cord_width_p-1:0]       win_dst_x_s;
   logic [y_cord_width_p-1:0]       win_dst_y_s;
   logic [payload_width_p-1:0]      win_payload_s;
   logic                            dst_illegal_s;
   packet_t                         packet_s;

   logic [num_req_p-1:0]            ready_s;
   logic                            accept_s;
   logic                            enq_s;
   logic                            deq_s;
   logic                            full_s;
   bsg_mesh_inject_q_op_e           q_op_s;

   packet_t                         head_data_r;
   packet_t                         tail_data_r;
   logic                            head_v_r;
   logic                            tail_v_r;
   packet_t                         head_data_n_s;
   packet_t                         tail_data_n_s;
   logic                            head_v_n_s;
   logic                            tail_v_n_s;

   logic                            err_r;
   logic [drop_count_width_lp-1:0]  drop_count_r;

   bsg_mesh_inject_rr_grant #(
      .num_req_p   (num_req_p),
      .ptr_width_p (ptr_width_lp)
   ) rr_grant (
      .reqs      (v_i),
      .rr_ptr    (rr_ptr_r),
      .grant     (grant_s),
      .winner    (winner_s),
      .any_grant (any_grant_s)
   );

   // Select the winner's fields and form its packet header
   always_comb begin
      win_dst_x_s   = dst_x_i[winner_s*x_cord_width_p +: x_cord_width_p];
      win_dst_y_s   = dst_y_i[winner_s*y_cord_width_p +: y_cord_width_p];
      win_payload_s = payload_i[winner_s*payload_width_p +: payload_width_p];
      dst_illegal_s = ({1'b0, win_dst_x_s} >= mesh_x_lp)
                    | ({1'b0, win_dst_y_s} >= mesh_y_lp);
      packet_s.payload = win_payload_s;
      packet_s.src_y   = my_y_i;
      packet_s.src_x   = my_x_i;
      packet_s.dst_y   = win_dst_y_s;
      packet_s.dst_x   = win_dst_x_s;
   end

   // Accept the winner when there is room or when its packet will be dropped.
   // yumi_i is deliberately not used here, so the router has no path to ready_o.
   always_comb begin
      full_s = head_v_r & tail_v_r;
      if (!reset_i && any_grant_s && (!full_s || dst_illegal_s)) begin
         ready_s = grant_s;
      end else begin
         ready_s = {num_req_p{1'b0}};
      end
      accept_s = |ready_s;
      enq_s    = accept_s & ~dst_illegal_s;
      deq_s    = yumi_i & head_v_r;
      q_op_s   = bsg_mesh_inject_q_op_e'({enq_s, deq_s});
   end

   // Next pointer: one past the winner, wrapping explicitly; hold with no accept
   always_comb begin
      if (accept_s) begin
         if (winner_s == ptr_width_lp'(num_req_p-1)) begin
            rr_ptr_n_s = {ptr_width_lp{1'b0}};
         end else begin
            rr_ptr_n_s = winner_s + ptr_width_lp'(1);
         end
      end else begin
         rr_ptr_n_s = rr_ptr_r;
      end
   end

   // Queue next state; the head register always feeds the router directly
   always_comb begin
      head_data_n_s = head_data_r;
      tail_data_n_s = tail_data_r;
      head_v_n_s    = head_v_r;
      tail_v_n_s    = tail_v_r;
      case (q_op_s)
         e_q_enq: begin
            if (head_v_r) begin
               tail_data_n_s = packet_s;
               tail_v_n_s    = 1'b1;
            end else begin
               head_data_n_s = packet_s;
               head_v_n_s    = 1'b1;
            end
         end
         e_q_deq: begin
            if (tail_v_r) begin
               head_data_n_s = tail_data_r;
               head_v_n_s    = 1'b1;
               tail_v_n_s    = 1'b0;
            end else begin
               head_data_n_s = '0;
               head_v_n_s    = 1'b0;
            end
         end
         // An enqueue only happens when not full, so occupancy here is one:
         // the head leaves and the new packet takes its place.
         e_q_both: begin
            head_data_n_s = packet_s;
            head_v_n_s    = 1'b1;
            tail_v_n_s    = 1'b0;
         end
         default: begin
            head_data_n_s = head_data_r;
            tail_data_n_s = tail_data_r;
            head_v_n_s    = head_v_r;
            tail_v_n_s    = tail_v_r;
         end
      endcase
   end

   // Queue registers; reset discards any flits still in flight
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         head_data_r <= '0;
         tail_data_r <= '0;
         head_v_r    <= 1'b0;
         tail_v_r    <= 1'b0;
      end else begin
         head_data_r <= head_data_n_s;
         tail_data_r <= tail_data_n_s;
         head_v_r    <= head_v_n_s;
         tail_v_r    <= tail_v_n_s;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rr_ptr_r <= {ptr_width_lp{1'b0}};
      end else begin
         rr_ptr_r <= rr_ptr_n_s;
      end
   end

   // Sticky error flag and saturating drop counter for bad destinations
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_r        <= 1'b0;
         drop_count_r <= {drop_count_width_lp{1'b0}};
      end else if (accept_s && dst_illegal_s) begin
         err_r        <= 1'b1;
         drop_count_r <= sat_inc(drop_count_r);
      end else begin
         err_r        <= err_r;
         drop_count_r <= drop_count_r;
      end
   end

   assign ready_o      = ready_s;
   assign v_o          = head_v_r;
   assign data_o       = head_data_r;
   assign err_o        = err_r;
   assign drop_count_o = drop_count_r;

endmodule

// File: tb/tb_bsg_mesh_inject_arbiter.sv
// Randomized scoreboard bench for bsg_mesh_inject_arbiter. A behavioural
// model predicts the grants, the queue occupancy and the drops. Expected
// flits go into a queue, and a monitor checks them as the router consumes them.
module tb_bsg_mesh_inject_arbiter;

   localparam int N  = 4;
   localparam int PW = 4;
   localparam int XW = 2;
   localparam int YW = 2;
   localparam int MX = 2;
   localparam int MY = 2;
   localparam int W  = 2*XW + 2*YW + PW;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic [XW-1:0]     my_x_i;
   logic [YW-1:0]     my_y_i;
   logic [N-1:0]      v_i;
   logic [N*XW-1:0]   dst_x_i;
   logic [N*YW-1:0]   dst_y_i;
   logic [N*PW-1:0]   payload_i;
   logic [N-1:0]      ready_o;
   logic              v_o;
   logic [W-1:0]      data_o;
   logic              yumi_i;
   logic              err_o;
   logic [7:0]        drop_count_o;

   bsg_mesh_inject_arbiter #(
      .num_req_p(N), .payload_width_p(PW), .x_cord_width_p(XW),
      .y_cord_width_p(YW), .mesh_x_p(MX), .mesh_y_p(MY)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
      .v_i(v_i), .dst_x_i(dst_x_i), .dst_y_i(dst_y_i), .payload_i(payload_i),
      .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
      .err_o(err_o), .drop_count_o(drop_count_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [W-1:0] sb_q[$];
   int           m_ptr;
   int           m_cnt;
   int           m_drops;
   int           m_err;
   int           acc_cnt[N];
   int           last_acc;

   // per-requester stimulus
   logic [XW-1:0] sdx[N];
   logic [YW-1:0] sdy[N];
   logic [PW-1:0] spay[N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // first valid requester at or after ptr, wrapping; -1 when none
   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int i = 0; i < N; i++) begin
         if (v[(ptr + i) % N]) return (ptr + i) % N;
      end
      return -1;
   endfunction

   // one clock cycle: drive, check combinational/registered outputs, advance model
   task automatic step(input logic [N-1:0] v, input bit yumi);
      int w;
      bit legal;
      logic [N-1:0] exp_ready;
      int enq;
      @(negedge clk_i);
      v_i    = v;
      yumi_i = yumi && (m_cnt > 0);
      for (int k = 0; k < N; k++) begin
         dst_x_i[k*XW +: XW]   = sdx[k];
         dst_y_i[k*YW +: YW]   = sdy[k];
         payload_i[k*PW +: PW] = spay[k];
      end
      #1;
      w = rr_pick(v, m_ptr);
      legal = 1'b0;
      exp_ready = '0;
      if (w >= 0) begin
         legal = (int'(sdx[w]) < MX) && (int'(sdy[w]) < MY);
         if (m_cnt < 2 || !legal) exp_ready[w] = 1'b1;
      end
      chk("ready_o", 32'(ready_o), 32'(exp_ready));
      chk("v_o", 32'(v_o), 32'(m_cnt > 0));
      chk("err_o", 32'(err_o), 32'(m_err));
      chk("drop_count_o", 32'(drop_count_o), 32'(m_drops));
      last_acc = 0;
      for (int k = 0; k < N; k++) begin
         if (v_i[k] && ready_o[k]) begin
            acc_cnt[k]++;
            last_acc++;
         end
      end
      enq = 0;
      if (exp_ready != '0) begin
         m_ptr = (w + 1) % N;
         if (legal) begin
            sb_q.push_back({spay[w], my_y_i, my_x_i, sdy[w], sdx[w]});
            enq = 1;
         end else begin
            m_err = 1;
            if (m_drops < 255) m_drops++;
         end
      end
      m_cnt = m_cnt + enq - (yumi_i ? 1 : 0);
   endtask

   task automatic model_reset();
      m_ptr = 0; m_cnt = 0; m_drops = 0; m_err = 0;
      sb_q.delete();
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && m_cnt > 0; i++) step('0, 1'b1);
   endtask

   task automatic clear_acc();
      for (int k = 0; k < N; k++) acc_cnt[k] = 0;
   endtask

   task automatic rand_legal_dsts();
      for (int k = 0; k < N; k++) begin
         sdx[k]  = XW'($urandom_range(0, MX-1));
         sdy[k]  = YW'($urandom_range(0, MY-1));
         spay[k] = PW'($urandom);
      end
   endtask

   // monitor: every router handshake must deliver the oldest expected flit
   initial begin
      logic [W-1:0] exp;
      forever begin
         @(negedge clk_i);
         #2;
         if (reset_i === 1'b0 && v_o === 1'b1 && yumi_i === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL data_o: got %0h expected no flit at %0t", data_o, $time);
            end else begin
               exp = sb_q.pop_front();
               chk("data_o", 32'(data_o), 32'(exp));
            end
         end
      end
   end

   initial begin
      int tot;
      reset_i = 1'b1; v_i = '1; yumi_i = 1'b0;
      dst_x_i = '0; dst_y_i = '0; payload_i = '0;
      my_x_i = '0; my_y_i = '0;
      for (int k = 0; k < N; k++) begin sdx[k] = '0; sdy[k] = '0; spay[k] = '0; end
      model_reset();
      clear_acc();
      #2;
      chk("reset ready_o", 32'(ready_o), 32'h0);
      chk("reset v_o", 32'(v_o), 32'h0);
      chk("reset data_o", 32'(data_o), 32'h0);
      chk("reset err_o", 32'(err_o), 32'h0);
      chk("reset drop_count_o", 32'(drop_count_o), 32'h0);
      @(negedge clk_i);
      v_i = '0;
      reset_i = 1'b0;

      // single packet from requester 0 to (1,0)
      sdx[0] = 2'd1; sdy[0] = 2'd0; spay[0] = 4'hA;
      step(4'b0001, 1'b0);
      chk("first ready_o", 32'(ready_o), 32'h1);
      step('0, 1'b1);
      chk("first v_o", 32'(v_o), 32'h1);
      chk("first data_o", 32'(data_o), 32'hA01);
      drain();

      // full contention with continuous consumption
      clear_acc();
      tot = 0;
      for (int i = 0; i < 100; i++) begin
         rand_legal_dsts();
         step(4'b1111, 1'b1);
         tot += last_acc;
      end
      chk("rotation total", 32'(tot), 32'd100);
      for (int k = 0; k < N; k++) chk("rotation share", 32'(acc_cnt[k]), 32'd25);
      drain();

      // queue fills with no consumption
      tot = 0;
      for (int i = 0; i < 4; i++) begin
         rand_legal_dsts();
         step(4'b1111, 1'b0);
         tot += last_acc;
      end
      chk("full accepts", 32'(tot), 32'd2);
      step(4'b1111, 1'b1);
      chk("no bypass", 32'(last_acc), 32'd0);
      step(4'b1111, 1'b0);
      chk("accept after deq", 32'(last_acc), 32'd1);
      drain();

      // bad destination from requester 2
      step(4'b0100, 1'b0);
      drain();
      sdx[2] = 2'd3; sdy[2] = 2'd0;
      step(4'b0100, 1'b0);
      chk("illegal ready_o", 32'(ready_o), 32'h4);
      step('0, 1'b0);
      chk("illegal err_o", 32'(err_o), 32'h1);
      chk("illegal drop_count_o", 32'(drop_count_o), 32'h1);
      chk("illegal no enqueue", 32'(v_o), 32'h0);
      step(4'b1111, 1'b0);
      chk("ptr after drop", 32'(ready_o), 32'h8);
      drain();

      // drop counter saturation
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < N; k++) begin
            sdx[k] = ($urandom_range(0, 1) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            sdy[k] = (sdx[k] >= 2'd2) ? 2'($urandom_range(0, 3)) : 2'(2 + $urandom_range(0, 1));
            spay[k] = PW'($urandom);
         end
         step(N'($urandom_range(1, 15)), 1'b1);
      end
      step('0, 1'b1);
      chk("drop saturation", 32'(drop_count_o), 32'd255);
      drain();

      // random traffic
      my_x_i = XW'($urandom); my_y_i = YW'($urandom);
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < N; k++) begin
            sdx[k]  = ($urandom_range(0, 9) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
            sdy[k]  = ($urandom_range(0, 9) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
            spay[k] = PW'($urandom);
         end
         step(N'($urandom), ($urandom_range(0, 1) == 1));
      end

      // asynchronous reset with two flits queued and a dropping requester granted
      drain();
      for (int i = 0; i < 8 && m_cnt < 2; i++) begin
         rand_legal_dsts();
         step(4'b1111, 1'b0);
      end
      chk("prefill count", 32'(m_cnt), 32'd2);
      for (int k = 0; k < N; k++) sdx[k] = 2'd3;
      @(negedge clk_i);
      v_i = 4'b1111; yumi_i = 1'b0;
      for (int k = 0; k < N; k++) dst_x_i[k*XW +: XW] = sdx[k];
      #1;
      chk("pre-reset ready_o nonzero", 32'(ready_o != '0), 32'h1);
      #2;
      reset_i = 1'b1;
      #1;
      chk("async v_o", 32'(v_o), 32'h0);
      chk("async ready_o", 32'(ready_o), 32'h0);
      chk("async err_o", 32'(err_o), 32'h0);
      chk("async drop_count_o", 32'(drop_count_o), 32'h0);
      chk("async data_o", 32'(data_o), 32'h0);
      @(negedge clk_i);
      v_i = '0;
      reset_i = 1'b0;
      model_reset();
      rand_legal_dsts();
      step(4'b1111, 1'b0);
      chk("post-reset grant", 32'(ready_o), 32'h1);
      drain();
      step('0, 1'b0);
      chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
